// File: rtl/pkg_memoria.sv
// Shared definitions for the data memory and the block-copy engine.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package pkg_memoria;

    // Words in the data memory.
    localparam int RAM_SIZE = 2048;

    // Data word width.
    localparam int WORD_W = 32;

    // Copy engine states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        CAPT  = 3'd2,
        WRITE = 3'd3,
        FIN   = 3'd4
    } state_t;

endpackage

// File: rtl/copiador_de_memoria.sv
// Block-copy engine on the data-memory port, memmove ordering, one word at a time.
// Latency: 3 cycles per word, done pulse one cycle after the last write; empty or faulting requests finish in 1 cycle.
// Backpressure: none; start is only sampled in IDLE and ignored while a copy runs.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   start               request, sampled with src_addr/dst_addr/length in IDLE
//   busy, done, error   status: copy in progress, end-of-request pulse, range fault on last request
//   mem_we, mem_addr, mem_datain, mem_dataout   data-memory initiator port (read data one cycle after address)
module copiador_de_memoria
    import pkg_memoria::*;
#(
    parameter int RAM_SIZE = pkg_memoria::RAM_SIZE,
    parameter int LEN_W    = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [31:0]         src_addr,
    input  logic [31:0]         dst_addr,
    input  logic [LEN_W-1:0]    length,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic                mem_we,
    output logic [31:0]         mem_addr,
    output logic [31:0]         mem_datain,
    input  logic [31:0]         mem_dataout
);

    state_t             state;
    state_t             state_nxt;
    logic               accept;

    logic [31:0]        src_ptr;
    logic [31:0]        dst_ptr;
    logic [LEN_W-1:0]   count;
    logic [31:0]        hold;
    logic               desc;

    // End addresses are formed 33 bits wide so a huge base cannot wrap
    // around and slip past the range check.
    logic [32:0]        src_end;
    logic [32:0]        dst_end;
    logic               fault;
    logic               dir_desc;
    logic [31:0]        len32;

    assign len32    = 32'(length);
    assign src_end  = {1'b0, src_addr} + {1'b0, len32};
    assign dst_end  = {1'b0, dst_addr} + {1'b0, len32};
    assign fault    = (src_end > 33'(RAM_SIZE)) || (dst_end > 33'(RAM_SIZE));
    // Destination starting inside the source block would overwrite source
    // words before they are read, so copy from the top end down.
    assign dir_desc = (src_addr < dst_addr) && ({1'b0, dst_addr} < src_end);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 32'd0;
        mem_datain = 32'd0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (length == '0 || fault) begin
                        state_nxt = FIN;
                    end else begin
                        state_nxt = READ;
                    end
                end
            end
            READ: begin
                busy      = 1'b1;
                mem_addr  = src_ptr;
                state_nxt = CAPT;
            end
            CAPT: begin
                busy      = 1'b1;
                state_nxt = WRITE;
            end
            WRITE: begin
                busy       = 1'b1;
                mem_we     = 1'b1;
                mem_addr   = dst_ptr;
                mem_datain = hold;
                state_nxt  = (count == LEN_W'(1)) ? FIN : READ;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src_ptr <= 32'd0;
            dst_ptr <= 32'd0;
            count   <= '0;
            hold    <= 32'd0;
            desc    <= 1'b0;
            error   <= 1'b0;
        end else begin
            if (accept) begin
                // An empty request is never a fault, whatever its addresses.
                error <= (length != '0) && fault;
                desc  <= dir_desc;
                count <= length;
                if (dir_desc) begin
                    src_ptr <= src_addr + len32 - 32'd1;
                    dst_ptr <= dst_addr + len32 - 32'd1;
                end else begin
                    src_ptr <= src_addr;
                    dst_ptr <= dst_addr;
                end
            end
            if (state == CAPT) begin
                hold <= mem_dataout;
            end
            if (state == WRITE) begin
                count <= count - LEN_W'(1);
                if (desc) begin
                    src_ptr <= src_ptr - 32'd1;
                    dst_ptr <= dst_ptr - 32'd1;
                end else begin
                    src_ptr <= src_ptr + 32'd1;
                    dst_ptr <= dst_ptr + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_copiador_de_memoria.sv
// Bench for the block-copy engine: behavioural RAM plus a memmove reference model.
module tb_copiador_de_memoria;

    localparam int RAM = 2048;
    localparam int LW  = 12;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [31:0]    src_addr;
    logic [31:0]    dst_addr;
    logic [LW-1:0]  length;
    logic           busy;
    logic           done;
    logic           error;
    logic           mem_we;
    logic [31:0]    mem_addr;
    logic [31:0]    mem_datain;
    logic [31:0]    mem_dataout;

    // backdoor preload port into the behavioural RAM
    logic           pl_we = 1'b0;
    logic [10:0]    pl_addr = '0;
    logic [31:0]    pl_dat = '0;

    logic [31:0]    mem    [0:RAM-1];
    logic [31:0]    refmem [0:RAM-1];
    logic [31:0]    we_q [$];

    int cmp_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    copiador_de_memoria #(.RAM_SIZE(RAM), .LEN_W(LW)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .src_addr    (src_addr),
        .dst_addr    (dst_addr),
        .length      (length),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_datain  (mem_datain),
        .mem_dataout (mem_dataout)
    );

    // synchronous RAM: registered read data one cycle after the address
    always @(posedge clk) begin
        if (pl_we)
            mem[pl_addr] <= pl_dat;
        else if (mem_we && mem_addr < RAM)
            mem[mem_addr[10:0]] <= mem_datain;
        mem_dataout <= mem[mem_addr[10:0]];
    end

    // every write the engine issues, in order
    always @(posedge clk) begin
        if (mem_we) we_q.push_back(mem_addr);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pl(input int a, input logic [31:0] d);
        @(negedge clk);
        pl_we   = 1'b1;
        pl_addr = 11'(a);
        pl_dat  = d;
        refmem[a] = d;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    function automatic int mem_diff();
        int bad = 0;
        for (int i = 0; i < RAM; i++)
            if (mem[i] !== refmem[i]) bad++;
        return bad;
    endfunction

    // memmove on the reference image: all source words are taken before any
    // destination word is written, which is what overlap-safe means.
    task automatic model_copy(input longint s, input longint d, input int l);
        logic [31:0] tmp [$];
        for (int i = 0; i < l; i++) tmp.push_back(refmem[s + i]);
        for (int i = 0; i < l; i++) refmem[d + i] = tmp[i];
    endtask

    // Issue one request; counts cycles after the accepting edge until done.
    task automatic run_copy(input longint s, input longint d, input int l,
                            input bit exp_busy, input int poke, input int rst_at,
                            output int ndone, output int busy_bad);
        ndone    = -1;
        busy_bad = 0;
        @(negedge clk);
        src_addr = 32'(s);
        dst_addr = 32'(d);
        length   = LW'(l);
        start    = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                ndone = n;
                if (busy !== 1'b0) busy_bad++;
                break;
            end
            if (busy !== exp_busy) busy_bad++;
            if (n == poke) begin
                src_addr = 32'd0;
                dst_addr = 32'h700;
                length   = LW'(2);
                start    = 1'b1;
            end
            if (n == rst_at) begin
                reset = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_copy(input string tag, input longint s, input longint d, input int l, input int poke);
        int  ndone, busy_bad, base, bad, nexp;
        bit  flt, dsc;
        longint a;
        flt  = (l != 0) && ((s + l > RAM) || (d + l > RAM));
        dsc  = (s < d) && (d < s + l);
        nexp = (l == 0 || flt) ? 0 : l;
        base = we_q.size();
        run_copy(s, d, l, 1'b1, poke, 0, ndone, busy_bad);
        check({tag, "_done_cycle"}, 64'(ndone), (nexp == 0) ? 64'd1 : 64'(3 * l + 1));
        check({tag, "_error"}, 64'(error), 64'(flt));
        check({tag, "_busy"}, 64'(busy_bad), 64'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        if (nexp != 0) model_copy(s, d, l);
        check({tag, "_we_count"}, 64'(we_q.size() - base), 64'(nexp));
        bad = 0;
        for (int j = 0; j < nexp && base + j < we_q.size(); j++) begin
            a = dsc ? d + l - 1 - j : d + j;
            if (we_q[base + j] !== 32'(a)) bad++;
        end
        check({tag, "_wr_order"}, 64'(bad), 64'd0);
        check({tag, "_mem"}, 64'(mem_diff()), 64'd0);
    endtask

    initial begin
        int ndone, busy_bad, base;
        bit saw_done;
        reset    = 1'b1;
        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        length   = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {busy, done, error, mem_we, mem_addr, mem_datain}, 64'd0);
        reset = 1'b0;

        for (int i = 0; i < RAM; i++) pl(i, $urandom);
        check("preload", 64'(mem_diff()), 64'd0);

        for (int i = 0; i < 4; i++) pl(10 + i, 32'hA0 + 32'(i));
        do_copy("asc", 10, 100, 4, 0);
        check("asc_data", 64'(mem[103]), 64'hA3);

        for (int i = 0; i < 5; i++) pl(20 + i, 32'(i + 1));
        do_copy("ovl_desc", 20, 22, 5, 0);

        for (int i = 0; i < 5; i++) pl(22 + i, 32'(i + 1));
        do_copy("ovl_asc", 22, 20, 5, 0);

        do_copy("fault", 2046, 0, 4, 0);
        do_copy("len0", 5, 6, 0, 0);
        do_copy("busy_start", 50, 150, 3, 2);

        // reset in cycle k+5 of a 4-word copy: only word 0 lands
        base = we_q.size();
        run_copy(300, 400, 4, 1'b1, 0, 5, ndone, busy_bad);
        @(negedge clk);
        check("rst_outputs", {busy, done, error, mem_we, mem_addr, mem_datain}, 64'd0);
        reset = 1'b0;
        saw_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("rst_no_done", 64'(saw_done), 64'd0);
        check("rst_we_count", 64'(we_q.size() - base), 64'd1);
        model_copy(300, 400, 1);
        check("rst_mem", 64'(mem_diff()), 64'd0);

        for (int t = 0; t < 16; t++) begin
            longint s, d;
            int l, off;
            l   = $urandom_range(1, 8);
            s   = (t % 4 == 3) ? $urandom_range(2040, 2047) : $urandom_range(0, 2030);
            off = $urandom_range(0, 16);
            d   = (s < 8) ? s + off : s + off - 8;
            if (t % 5 == 4) d = $urandom_range(0, 2047);
            do_copy("rand", s, d, l, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
